e_to_m_stage: RTL and testbench
===============================

# e_to_m_stage

Parametrised Execute-to-Memory stage register for the pipelined OTTER core. It replaces the free-running E→M register with a valid/ready stage and a two-entry skid buffer, so the Memory stage can stall without a combinational ready path back into Execute. It also adds a synchronous flush, bubble gating of side-effect controls, and a saturating stall-cycle counter. It sits between the Execute datapath/ALU and the data-memory interface.

## Interface
Parameters:
- XLEN, 32, datapath width (ALUResult, RD2, PCPlus4)
- REG_AW, 5, register-file address width (Rd)
- CNT_W, 16, stall counter width

Ports:
- CLK  in  1  core clock
- RST_N  in  1  reset; asynchronous, active-low
- ValidE  in  1  Execute holds a real instruction
- ReadyE  out  1  stage can accept; transfer on ValidE && ReadyE
- RegWriteE, MemWriteE, MemSignE  in  1 each  controls from Execute
- ResultSrcE, MemSizeE  in  2 each  result select, access size
- ALUResultE, RD2E, PCPlus4E  in  XLEN each  datapath values
- RdE  in  REG_AW  destination register
- FlushM  in  1  squash held and incoming instructions
- ReadyM  in  1  Memory stage accepts; transfer on ValidM && ReadyM
- ValidM  out  1  output holds a real instruction
- RegWriteM, MemWriteM, MemSignM, ResultSrcM, MemSizeM, ALUResultM, WriteDataM (from RD2E), RdM, PCPlus4M  out  widths as the E inputs  registered payload
- StallCycles  out  CNT_W  saturating count of ValidM && !ReadyM cycles

## Operation
- Two payload slots: main (drives the M outputs) and skid. There are three states:
  - EMPTY: main invalid, skid invalid
  - FULL: main valid, skid invalid
  - SKID: both valid
- ReadyE = (state != SKID). It is a registered decode of the state and never depends combinationally on ReadyM.
- Transitions, with FlushM = 0:
  - EMPTY: ValidE → main <= in, go to FULL; otherwise stay EMPTY.
  - FULL, ReadyM && ValidE → main <= in, stay FULL.
  - FULL, ReadyM && !ValidE → go to EMPTY.
  - FULL, !ReadyM && ValidE → skid <= in, go to SKID.
  - FULL, !ReadyM && !ValidE → hold.
  - SKID, ReadyM → main <= skid, go to FULL. No input is accepted because ReadyE = 0.
  - SKID, !ReadyM → hold.
- FlushM = 1 takes priority over everything:
  - Next state is EMPTY.
  - The incoming beat is discarded even if ValidE && ReadyE.
  - Payload registers may keep stale data.
- Bubble gating: while ValidM = 0, RegWriteM and MemWriteM are driven 0 regardless of stored payload. Other fields are don't-care but stable.
- StallCycles increments by 1 on each cycle with ValidM && !ReadyM and stops at 2^CNT_W−1. Only reset clears it; FlushM does not.

## Timing
- Reset (RST_N low, async): state EMPTY, ValidM = 0, ReadyE = 1, all payload outputs 0, StallCycles = 0.
- Latency: a beat accepted at edge n appears on the M outputs after edge n (one cycle). Throughput is 1 beat/cycle while ReadyM = 1.
- Backpressure: the first !ReadyM cycle with a valid input fills skid. ReadyE drops the following cycle. At most one extra beat is absorbed, so nothing is ever lost or duplicated.
- Release: one ReadyM cycle in SKID moves skid→main. ReadyE rises the next cycle.
- Order is strictly preserved (FIFO, depth 2).
- Reset asserted mid-operation drops both entries immediately. Deassertion is synchronised outside this block.
- FlushM and ReadyM in the same cycle: the main beat counts as consumed by M (its handshake completes), and the stage still becomes EMPTY.

## Structure
- Shared package `otter_pipe_pkg`:
  - `em_payload_t` packed struct holding all E→M fields, sized by XLEN/REG_AW
  - `skid_state_t` enum {EMPTY, FULL, SKID}
- Sub-module `pipe_skid_buffer`:
  - generic over a payload width, with valid/ready/flush and the state machine above
  - this block instantiates it on `em_payload_t`, and adds bubble gating and the stall counter
- The same sub-module is intended for the F→D, D→E and M→W stages.

## Test plan
- **Reset:** assert RST_N = 0 mid-stream with both slots full → ValidM = 0, ReadyE = 1, all outputs 0, StallCycles = 0 asynchronously.
- **Streaming:** ReadyM = 1, ValidE every cycle with ALUResultE = 0x10, 0x20, 0x30 → ALUResultM shows 0x10, 0x20, 0x30 on consecutive cycles, one cycle delayed, ValidM = 1.
- **Backpressure:**
  - Stimulus: stream A, B, C, D with ReadyM = 0 for 3 cycles starting when A is in main.
  - During the stall: B is held in skid, ReadyE = 0 the cycle after B is captured, and C is held at the input.
  - Result: StallCycles = 3, and the output sequence after release is A, B, C, D with no loss or duplication.
- **Flush:** SKID state plus ValidE = 1 with FlushM = 1 → next cycle EMPTY, ValidM = 0, RegWriteM = MemWriteM = 0, and the incoming beat is not seen later.
- **Bubble gating:** ValidE = 0 with RegWriteE = MemWriteE = 1 → RegWriteM = MemWriteM = 0 and ValidM = 0.
- **Saturation:** with CNT_W = 4, hold ReadyM = 0 with ValidM = 1 for 20 cycles → StallCycles = 15 and stays there.

Source files
------------

// File: rtl/otter_pipe_pkg.sv
// Shared types for the OTTER pipeline stage registers: the skid-buffer state
// encoding and the default-width Execute-to-Memory payload record.
package otter_pipe_pkg;

    localparam int OTTER_XLEN   = 32;
    localparam int OTTER_REG_AW = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic                    reg_write;
        logic                    mem_write;
        logic                    mem_sign;
        logic [1:0]              result_src;
        logic [1:0]              mem_size;
        logic [OTTER_XLEN-1:0]   alu_result;
        logic [OTTER_XLEN-1:0]   write_data;
        logic [OTTER_REG_AW-1:0] rd;
        logic [OTTER_XLEN-1:0]   pc_plus4;
    } em_payload_t;

    // Payload width for stages instantiated with non-default widths.
    function automatic int em_payload_bits(input int xlen, input int reg_aw);
        return 7 + 3 * xlen + reg_aw;
    endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic two-entry valid/ready pipeline register. in_ready_o is a pure decode
// of the registered state, so downstream ready never reaches upstream combinationally.
module pipe_skid_buffer
    import otter_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        // Flush wins; payload slots are left stale since validity lives in the state.
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_valid_i) begin
                        main_d  = in_data_i;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (out_ready_i) begin
                        if (in_valid_i) begin
                            main_d = in_data_i;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else if (in_valid_i) begin
                        skid_d  = in_data_i;
                        state_d = SKID;
                    end
                end
                SKID: begin
                    if (out_ready_i) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign in_ready_o  = (state_q != SKID);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;

endmodule

// File: rtl/e_to_m_stage.sv
// Execute-to-Memory stage register: skid-buffered E->M payload with bubble
// gating of the side-effect controls and a saturating stall-cycle counter.
module e_to_m_stage
    import otter_pipe_pkg::*;
#(
    parameter int XLEN   = OTTER_XLEN,
    parameter int REG_AW = OTTER_REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ValidE,
    output logic              ReadyE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              MemSignE,
    input  logic [1:0]        ResultSrcE,
    input  logic [1:0]        MemSizeE,
    input  logic [XLEN-1:0]   ALUResultE,
    input  logic [XLEN-1:0]   RD2E,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              FlushM,
    input  logic              ReadyM,
    output logic              ValidM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              MemSignM,
    output logic [1:0]        ResultSrcM,
    output logic [1:0]        MemSizeM,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [REG_AW-1:0] RdM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [CNT_W-1:0]  StallCycles
);

    // Same field layout as em_payload_t, but sized by this instance's parameters.
    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              mem_sign;
        logic [1:0]        result_src;
        logic [1:0]        mem_size;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   write_data;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc_plus4;
    } payload_t;

    localparam int PW = $bits(payload_t);

    payload_t         in_pl;
    payload_t         out_pl;
    logic             valid_m;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        in_pl            = '0;
        in_pl.reg_write  = RegWriteE;
        in_pl.mem_write  = MemWriteE;
        in_pl.mem_sign   = MemSignE;
        in_pl.result_src = ResultSrcE;
        in_pl.mem_size   = MemSizeE;
        in_pl.alu_result = ALUResultE;
        in_pl.write_data = RD2E;
        in_pl.rd         = RdE;
        in_pl.pc_plus4   = PCPlus4E;
    end

    pipe_skid_buffer #(
        .W (PW)
    ) u_skid (
        .clk         (CLK),
        .rst_n       (RST_N),
        .flush_i     (FlushM),
        .in_valid_i  (ValidE),
        .in_ready_o  (ReadyE),
        .in_data_i   (in_pl),
        .out_valid_o (valid_m),
        .out_ready_i (ReadyM),
        .out_data_o  (out_pl)
    );

    // Bubbles must never write the register file or memory, whatever the stale payload holds.
    assign ValidM     = valid_m;
    assign RegWriteM  = valid_m & out_pl.reg_write;
    assign MemWriteM  = valid_m & out_pl.mem_write;
    assign MemSignM   = out_pl.mem_sign;
    assign ResultSrcM = out_pl.result_src;
    assign MemSizeM   = out_pl.mem_size;
    assign ALUResultM = out_pl.alu_result;
    assign WriteDataM = out_pl.write_data;
    assign RdM        = out_pl.rd;
    assign PCPlus4M   = out_pl.pc_plus4;

    always_comb begin
        cnt_d = cnt_q;
        if (valid_m && !ReadyM && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign StallCycles = cnt_q;

endmodule

// File: tb/tb_e_to_m_stage.sv
// Directed, table-driven bench for e_to_m_stage (CNT_W = 4 so saturation is reachable).
module tb_e_to_m_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ValidE, ReadyE;
    logic        RegWriteE, MemWriteE, MemSignE;
    logic [1:0]  ResultSrcE, MemSizeE;
    logic [31:0] ALUResultE, RD2E, PCPlus4E;
    logic [4:0]  RdE;
    logic        FlushM, ReadyM, ValidM;
    logic        RegWriteM, MemWriteM, MemSignM;
    logic [1:0]  ResultSrcM, MemSizeM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic [3:0]  StallCycles;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    e_to_m_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ValidE(ValidE), .ReadyE(ReadyE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemSignE(MemSignE),
        .ResultSrcE(ResultSrcE), .MemSizeE(MemSizeE),
        .ALUResultE(ALUResultE), .RD2E(RD2E), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .FlushM(FlushM), .ReadyM(ReadyM), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemSignM(MemSignM),
        .ResultSrcM(ResultSrcM), .MemSizeM(MemSizeM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .StallCycles(StallCycles)
    );

    typedef struct {
        logic [4:0]  in_b;   // {ValidE, ReadyM, FlushM, RegWriteE, MemWriteE}
        logic [31:0] alu;
        logic [4:0]  exp_b;  // {ValidM, ReadyE, check_alu, RegWriteM, MemWriteM}
        logic [31:0] ealu;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic [4:0] in_b, input logic [31:0] alu,
                                input logic [4:0] exp_b, input logic [31:0] ealu,
                                input logic [3:0] ecnt);
        vec_t v;
        v.in_b = in_b; v.alu = alu; v.exp_b = exp_b; v.ealu = ealu; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rm, input logic fl,
                         input logic rw, input logic mw, input logic [31:0] alu);
        ValidE     = v;
        ReadyM     = rm;
        FlushM     = fl;
        RegWriteE  = rw;
        MemWriteE  = mw;
        MemSignE   = alu[0];
        ResultSrcE = alu[5:4];
        MemSizeE   = alu[7:6];
        ALUResultE = alu;
        RD2E       = alu + 32'd1;
        PCPlus4E   = alu + 32'd4;
        RdE        = alu[4:0];
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Streaming, bubble gating
        tbl[0]  = mk(5'b11010, 32'h10, 5'b11110, 32'h10, 4'd0);
        tbl[1]  = mk(5'b11001, 32'h20, 5'b11101, 32'h20, 4'd0);
        tbl[2]  = mk(5'b11011, 32'h30, 5'b11111, 32'h30, 4'd0);
        tbl[3]  = mk(5'b01011, 32'h99, 5'b01000, 32'h0,  4'd0);
        tbl[4]  = mk(5'b01011, 32'h99, 5'b01000, 32'h0,  4'd0);
        // Backpressure: A=40 B=50 C=60 D=70, ReadyM low for 3 cycles with A in main
        tbl[5]  = mk(5'b11011, 32'h40, 5'b11111, 32'h40, 4'd0);
        tbl[6]  = mk(5'b10011, 32'h50, 5'b10111, 32'h40, 4'd1);
        tbl[7]  = mk(5'b10011, 32'h60, 5'b10111, 32'h40, 4'd2);
        tbl[8]  = mk(5'b10011, 32'h60, 5'b10111, 32'h40, 4'd3);
        tbl[9]  = mk(5'b11011, 32'h60, 5'b11111, 32'h50, 4'd3);
        tbl[10] = mk(5'b11011, 32'h60, 5'b11111, 32'h60, 4'd3);
        tbl[11] = mk(5'b11011, 32'h70, 5'b11111, 32'h70, 4'd3);
        tbl[12] = mk(5'b01011, 32'h77, 5'b01000, 32'h0,  4'd3);
        // Flush from SKID with a valid incoming beat, then flush together with ReadyM
        tbl[13] = mk(5'b11011, 32'h80, 5'b11111, 32'h80, 4'd3);
        tbl[14] = mk(5'b10000, 32'h90, 5'b10111, 32'h80, 4'd4);
        tbl[15] = mk(5'b10111, 32'hA0, 5'b01000, 32'h0,  4'd5);
        tbl[16] = mk(5'b01011, 32'hA0, 5'b01000, 32'h0,  4'd5);
        tbl[17] = mk(5'b11000, 32'hB0, 5'b11100, 32'hB0, 4'd5);
        tbl[18] = mk(5'b11111, 32'hC0, 5'b01000, 32'h0,  4'd5);
        tbl[19] = mk(5'b01011, 32'hC0, 5'b01000, 32'h0,  4'd5);

        RST_N = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        #12;
        chk("reset_validm", {31'd0, ValidM}, 32'd0);
        chk("reset_readye", {31'd0, ReadyE}, 32'd1);
        chk("reset_alu",    ALUResultM, 32'd0);
        chk("reset_regw",   {31'd0, RegWriteM}, 32'd0);
        chk("reset_cnt",    {28'd0, StallCycles}, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].in_b[4], tbl[i].in_b[3], tbl[i].in_b[2],
                  tbl[i].in_b[1], tbl[i].in_b[0], tbl[i].alu);
            step();
            $display("[TB] vec %0d: ValidM=%0b ReadyE=%0b ALUResultM=%h StallCycles=%0d",
                     i, ValidM, ReadyE, ALUResultM, StallCycles);
            chk($sformatf("vec%0d_validm", i), {31'd0, ValidM},    {31'd0, tbl[i].exp_b[4]});
            chk($sformatf("vec%0d_readye", i), {31'd0, ReadyE},    {31'd0, tbl[i].exp_b[3]});
            chk($sformatf("vec%0d_regw", i),   {31'd0, RegWriteM}, {31'd0, tbl[i].exp_b[1]});
            chk($sformatf("vec%0d_memw", i),   {31'd0, MemWriteM}, {31'd0, tbl[i].exp_b[0]});
            chk($sformatf("vec%0d_cnt", i),    {28'd0, StallCycles}, {28'd0, tbl[i].ecnt});
            if (tbl[i].exp_b[2]) begin
                chk($sformatf("vec%0d_alu", i),  ALUResultM, tbl[i].ealu);
                chk($sformatf("vec%0d_wdata", i), WriteDataM, tbl[i].ealu + 32'd1);
            end
        end

        // Saturation: hold one beat under backpressure for 20 cycles from count 5
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hD0);
        step();
        chk("sat_load_alu", ALUResultM, 32'hD0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hEE);
        for (int i = 0; i < 20; i++) begin
            int e;
            step();
            e = (6 + i > 15) ? 15 : 6 + i;
            $display("[TB] sat %0d: StallCycles=%0d ValidM=%0b", i, StallCycles, ValidM);
            chk($sformatf("sat%0d_cnt", i), {28'd0, StallCycles}, e);
            chk($sformatf("sat%0d_alu", i), ALUResultM, 32'hD0);
        end

        // Asynchronous reset with both slots occupied
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hE0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hF0);
        step();
        chk("pre_rst_readye", {31'd0, ReadyE}, 32'd0);
        chk("pre_rst_alu", ALUResultM, 32'hE0);
        #2;
        RST_N = 1'b0;
        #1;
        $display("[TB] async reset: ValidM=%0b ReadyE=%0b StallCycles=%0d", ValidM, ReadyE, StallCycles);
        chk("arst_validm", {31'd0, ValidM}, 32'd0);
        chk("arst_readye", {31'd0, ReadyE}, 32'd1);
        chk("arst_alu",    ALUResultM, 32'd0);
        chk("arst_wdata",  WriteDataM, 32'd0);
        chk("arst_memw",   {31'd0, MemWriteM}, 32'd0);
        chk("arst_cnt",    {28'd0, StallCycles}, 32'd0);
        step();
        RST_N = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("post_rst_validm", {31'd0, ValidM}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
